// File: rtl/frame_buffer_write_ctrl.sv
// Frame buffer write-side controller: packs an 8-bit raster stream into
// memory words and walks a stride-based word address across the frame.
module frame_buffer_write_ctrl #(
    parameter int MEM_WIDTH  = 64,
    parameter int DIM_WIDTH  = 12,
    parameter int ADDR_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  setup_frame,
    input  logic [DIM_WIDTH-1:0]  stride_in,
    input  logic [DIM_WIDTH-1:0]  width_in,
    input  logic [DIM_WIDTH-1:0]  height_in,
    input  logic                  pix_valid,
    input  logic [7:0]            pix_data,
    output logic                  pix_ready,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [MEM_WIDTH-1:0]  mem_wr_data,
    input  logic                  mem_wr_ready,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int BYTES = MEM_WIDTH / 8;
    localparam int SH    = $clog2(BYTES);
    localparam int BW    = (SH > 0) ? SH : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [DIM_WIDTH-1:0]  stride_q, stride_d;
    logic [DIM_WIDTH-1:0]  width_q, width_d;
    logic [DIM_WIDTH-1:0]  height_q, height_d;
    logic [DIM_WIDTH-1:0]  line_q, line_d;
    logic [DIM_WIDTH-1:0]  col_q, col_d;
    logic [ADDR_WIDTH-1:0] line_base_q, line_base_d;
    logic [BW-1:0]         byte_idx_q, byte_idx_d;
    logic [MEM_WIDTH-1:0]  word_q, word_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  pix_ready_q, pix_ready_d;
    logic                  wr_en_q, wr_en_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [DIM_WIDTH:0]    col_next;
    logic [DIM_WIDTH:0]    line_next;
    logic [ADDR_WIDTH-1:0] line_step;
    logic [ADDR_WIDTH-1:0] col_word;
    logic                  pix_fire;

    assign col_next  = {1'b0, col_q} + (DIM_WIDTH+1)'(BYTES);
    assign line_next = {1'b0, line_q} + 1'b1;
    assign line_step = ADDR_WIDTH'(stride_q >> SH);
    assign col_word  = ADDR_WIDTH'(col_q >> SH);
    assign pix_fire  = pix_valid && pix_ready_q;

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d     = state_q;
        stride_d    = stride_q;
        width_d     = width_q;
        height_d    = height_q;
        line_d      = line_q;
        col_d       = col_q;
        line_base_d = line_base_q;
        byte_idx_d  = byte_idx_q;
        word_d      = word_q;
        addr_d      = addr_q;
        unique case (state_q)
            IDLE: begin
                if (setup_frame && (width_in != '0) && (height_in != '0)) begin
                    stride_d    = stride_in;
                    width_d     = width_in;
                    height_d    = height_in;
                    line_d      = '0;
                    col_d       = '0;
                    line_base_d = '0;
                    byte_idx_d  = '0;
                    state_d     = FILL;
                end
            end
            FILL: begin
                if (pix_fire) begin
                    for (int k = 0; k < BYTES; k++) begin
                        if (byte_idx_q == BW'(k)) begin
                            word_d[8*k +: 8] = pix_data;
                        end
                    end
                    if (byte_idx_q == BW'(BYTES - 1)) begin
                        byte_idx_d = '0;
                        addr_d     = line_base_q + col_word;
                        state_d    = WRITE;
                    end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                    end
                end
            end
            WRITE: begin
                if (mem_wr_ready) begin
                    if (col_next == {1'b0, width_q}) begin
                        col_d       = '0;
                        line_d      = line_next[DIM_WIDTH-1:0];
                        line_base_d = line_base_q + line_step;
                        if (line_next == {1'b0, height_q}) begin
                            state_d = DONE;
                        end else begin
                            state_d = FILL;
                        end
                    end else begin
                        col_d   = col_next[DIM_WIDTH-1:0];
                        state_d = FILL;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        pix_ready_d = (state_d == FILL);
        wr_en_d     = (state_d == WRITE);
        busy_d      = (state_d == FILL) || (state_d == WRITE);
        done_d      = (state_d == DONE);
    end

    // State, counters and outputs register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            stride_q    <= '0;
            width_q     <= '0;
            height_q    <= '0;
            line_q      <= '0;
            col_q       <= '0;
            line_base_q <= '0;
            byte_idx_q  <= '0;
            word_q      <= '0;
            addr_q      <= '0;
            pix_ready_q <= 1'b0;
            wr_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            stride_q    <= stride_d;
            width_q     <= width_d;
            height_q    <= height_d;
            line_q      <= line_d;
            col_q       <= col_d;
            line_base_q <= line_base_d;
            byte_idx_q  <= byte_idx_d;
            word_q      <= word_d;
            addr_q      <= addr_d;
            pix_ready_q <= pix_ready_d;
            wr_en_q     <= wr_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign pix_ready   = pix_ready_q;
    assign mem_wr_en   = wr_en_q;
    assign mem_wr_addr = addr_q;
    assign mem_wr_data = word_q;
    assign busy        = busy_q;
    assign frame_done  = done_q;

endmodule

// File: tb/tb_frame_buffer_write_ctrl.sv
// Testbench for frame_buffer_write_ctrl: queue-based scoreboard fed by a
// frame-level reference model, with randomized source and sink pacing.
module tb_frame_buffer_write_ctrl;

    localparam int MW = 64;
    localparam int DW = 12;
    localparam int AW = 24;
    localparam int B  = MW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          setup_frame;
    logic [DW-1:0] stride_in;
    logic [DW-1:0] width_in;
    logic [DW-1:0] height_in;
    logic          pix_valid;
    logic [7:0]    pix_data;
    logic          pix_ready;
    logic          mem_wr_en;
    logic [AW-1:0] mem_wr_addr;
    logic [MW-1:0] mem_wr_data;
    logic          mem_wr_ready;
    logic          busy;
    logic          frame_done;

    frame_buffer_write_ctrl #(
        .MEM_WIDTH(MW), .DIM_WIDTH(DW), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst(rst), .setup_frame(setup_frame),
        .stride_in(stride_in), .width_in(width_in), .height_in(height_in),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data), .mem_wr_ready(mem_wr_ready),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [MW-1:0] d;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] src_q[$];
    logic [7:0] fb[$];

    int total = 0;
    int bad = 0;
    int done_seen = 0;
    int done_exp = 0;
    int acc_cnt = 0;
    int cyc = 0;
    int last_acc = -10;
    int held_len = 0;
    int t2_len = -1;
    int stall_idx = -1;
    int stall_left = 0;
    int mark_idx = -1;
    logic rnd_valid = 1'b0;
    logic rnd_ready = 1'b0;
    logic [AW-1:0] last_addr = '0;
    logic [MW-1:0] last_data = '0;
    logic [MW-1:0] cap_data = '0;

    task automatic check(input string n, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, act, exp);
        end
    endtask

    // Reference model: every word of the frame, in raster order
    task automatic build_model(input int s, input int w, input int h);
        wr_t e;
        for (int l = 0; l < h; l++) begin
            for (int c = 0; c < w / B; c++) begin
                e.a = AW'(l * (s / B) + c);
                for (int k = 0; k < B; k++)
                    e.d[8*k +: 8] = fb[l * w + c * B + k];
                exp_q.push_back(e);
            end
        end
        done_exp++;
    endtask

    task automatic setup(input int s, input int w, input int h);
        @(posedge clk); #1;
        setup_frame = 1'b1;
        stride_in = DW'(s);
        width_in = DW'(w);
        height_in = DW'(h);
        @(posedge clk); #1;
        setup_frame = 1'b0;
    endtask

    task automatic start_frame(input int s, input int w, input int h);
        if (w != 0 && h != 0) build_model(s, w, h);
        foreach (fb[i]) src_q.push_back(fb[i]);
        setup(s, w, h);
    endtask

    task automatic wait_done(input int target, input int bound);
        int i;
        i = 0;
        while (done_seen < target && i < bound) begin
            @(posedge clk);
            i++;
        end
        check("done_timeout", 64'(done_seen >= target), 1);
        repeat (3) @(posedge clk);
    endtask

    task automatic do_rst;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic fill_seq(input int n);
        fb.delete();
        for (int i = 0; i < n; i++) fb.push_back(8'(i));
    endtask

    task automatic fill_rand(input int n);
        fb.delete();
        for (int i = 0; i < n; i++) fb.push_back(8'($urandom));
    endtask

    // Pixel source: offers queued bytes, pops one per handshake
    initial begin
        logic fire;
        pix_valid = 1'b0;
        pix_data = '0;
        forever begin
            @(negedge clk);
            fire = pix_valid && pix_ready;
            @(posedge clk); #1;
            if (fire && src_q.size() > 0) void'(src_q.pop_front());
            if (src_q.size() > 0 &&
                (!rnd_valid || $urandom_range(0, 3) != 0)) begin
                pix_valid = 1'b1;
                pix_data = src_q[0];
            end else begin
                pix_valid = 1'b0;
            end
        end
    end

    // Memory sink: ready pacing plus a forced stall for one chosen word
    initial begin
        mem_wr_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (mem_wr_en && acc_cnt == stall_idx && stall_left > 0) begin
                mem_wr_ready = 1'b0;
                stall_left--;
            end else begin
                mem_wr_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard on each accepted write
    initial begin
        wr_t e;
        logic pv_en, pv_rdy;
        logic [AW-1:0] pv_a;
        logic [MW-1:0] pv_d;
        pv_en = 1'b0;
        pv_rdy = 1'b1;
        pv_a = '0;
        pv_d = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                if (pv_en && !pv_rdy) begin
                    check("hold_en", 64'(mem_wr_en), 1);
                    check("hold_addr", 64'(mem_wr_addr), 64'(pv_a));
                    check("hold_data", mem_wr_data, pv_d);
                end
                if (mem_wr_en) begin
                    held_len++;
                    check("pix_ready_in_write", 64'(pix_ready), 0);
                end
                if (mem_wr_en && mem_wr_ready) begin
                    if (acc_cnt == stall_idx) t2_len = held_len;
                    if (acc_cnt == mark_idx) cap_data = mem_wr_data;
                    held_len = 0;
                    acc_cnt++;
                    last_acc = cyc;
                    last_addr = mem_wr_addr;
                    last_data = mem_wr_data;
                    if (exp_q.size() == 0) begin
                        check("unexpected_write", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", 64'(mem_wr_addr), 64'(e.a));
                        check("wr_data", mem_wr_data, e.d);
                    end
                end
                if (frame_done) begin
                    done_seen++;
                    check("done_latency", 64'(cyc), 64'(last_acc + 1));
                    check("done_pending", 64'(exp_q.size()), 0);
                end
            end else begin
                held_len = 0;
            end
            pv_en = mem_wr_en;
            pv_rdy = mem_wr_ready;
            pv_a = mem_wr_addr;
            pv_d = mem_wr_data;
        end
    end

    initial begin
        wr_t e;
        int s, w, h, n;
        rst = 1'b1;
        setup_frame = 1'b0;
        stride_in = '0;
        width_in = '0;
        height_in = '0;
        do_rst();
        @(negedge clk);
        check("rst_pix_ready", 64'(pix_ready), 0);
        check("rst_wr_en", 64'(mem_wr_en), 0);
        check("rst_wr_addr", 64'(mem_wr_addr), 0);
        check("rst_wr_data", mem_wr_data, 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_frame_done", 64'(frame_done), 0);

        // Basic two-line frame
        fill_seq(32);
        mark_idx = acc_cnt;
        start_frame(32, 16, 2);
        wait_done(done_exp, 2000);
        check("t1_first_data", cap_data, 64'h0706050403020100);
        check("t1_last_addr", 64'(last_addr), 5);
        check("t1_last_data", last_data, 64'h1F1E1D1C1B1A1918);

        // Three-cycle stall on the second write
        stall_idx = acc_cnt + 1;
        stall_left = 3;
        start_frame(32, 16, 2);
        wait_done(done_exp, 2000);
        check("t2_hold_len", 64'(t2_len), 4);
        stall_idx = -1;

        // Setup mid-frame is ignored
        start_frame(32, 16, 2);
        repeat (10) @(posedge clk);
        setup(32, 64, 2);
        wait_done(done_exp, 2000);
        check("t3_last_addr", 64'(last_addr), 5);

        // Zero width / zero height never start a frame
        setup(32, 0, 2);
        setup(32, 16, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t4_busy", 64'(busy), 0);
            check("t4_wr_en", 64'(mem_wr_en), 0);
        end

        // Reset after 12 bytes, then a clean frame
        fill_seq(12);
        e.a = '0;
        e.d = 64'h0706050403020100;
        exp_q.push_back(e);
        foreach (fb[i]) src_q.push_back(fb[i]);
        setup(32, 16, 2);
        n = 0;
        while (src_q.size() > 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        check("t5_bytes_taken", 64'(src_q.size()), 0);
        @(posedge clk);
        do_rst();
        check("t5_word0_written", 64'(exp_q.size()), 0);
        exp_q.delete();
        src_q.delete();
        @(negedge clk);
        check("t5_busy_after_rst", 64'(busy), 0);
        fill_seq(32);
        mark_idx = acc_cnt;
        start_frame(32, 16, 2);
        wait_done(done_exp, 2000);
        check("t5_first_data", cap_data, 64'h0706050403020100);

        // Large stride/width with a short height
        fill_rand(1920 * 3);
        start_frame(2048, 1920, 3);
        wait_done(done_exp, 20000);
        check("big_last_addr", 64'(last_addr), 751);

        // Random dims with random source/sink pacing
        rnd_valid = 1'b1;
        rnd_ready = 1'b1;
        for (int f = 0; f < 6; f++) begin
            w = B * $urandom_range(1, 6);
            s = w + B * $urandom_range(0, 3);
            h = $urandom_range(1, 4);
            fill_rand(w * h);
            start_frame(s, w, h);
            wait_done(done_exp, 6000);
        end
        rnd_valid = 1'b0;
        rnd_ready = 1'b0;
        repeat (10) @(posedge clk);

        check("done_count", 64'(done_seen), 64'(done_exp));
        check("queue_empty", 64'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
